// File: rtl/einstein_kbd_pkg.sv
// Shared types and constants for the Einstein PS/2 keyboard matrix: receiver states,
// scan-code prefixes, modifier encodings and the map-entry layout.
package einstein_kbd_pkg;

  localparam int DEF_FILTER_LEN     = 8;
  localparam int DEF_TIMEOUT_CYCLES = 64000;

  localparam logic [7:0] PFX_EXT   = 8'hE0;
  localparam logic [7:0] PFX_BRK   = 8'hF0;
  localparam logic [7:0] PFX_PAUSE = 8'hE1;
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    MOD_NONE,
    MOD_SHIFT,
    MOD_CTRL,
    MOD_GRAPH
  } mod_t;

  typedef struct packed {
    logic       valid;
    mod_t       mod;
    logic [2:0] row;
    logic [2:0] col;
  } map_entry_t;

  function automatic map_entry_t mk_key(input logic [2:0] r, input logic [2:0] c);
    return '{valid: 1'b1, mod: MOD_NONE, row: r, col: c};
  endfunction

  // For SHIFT the col field tells the left (0) and right (1) keys apart.
  function automatic map_entry_t mk_mod(input mod_t m, input logic [2:0] c);
    return '{valid: 1'b1, mod: m, row: 3'd0, col: c};
  endfunction

endpackage

// File: rtl/einstein_kbd_matrix_if.sv
// Machine-side keyboard nets: row strobe from PSG port A, column and modifier
// returns to port B, all active low.
interface einstein_kbd_matrix_if;
  logic [7:0] kb_row;
  logic [7:0] kb_col;
  logic       kb_shift;
  logic       kb_ctrl;
  logic       kb_graph;

  modport master (input kb_row, output kb_col, kb_shift, kb_ctrl, kb_graph);
  modport slave  (output kb_row, input kb_col, kb_shift, kb_ctrl, kb_graph);
endinterface

// File: rtl/einstein_kbd_map.sv
// Combinational scan-code lookup: {ext, code} -> {valid, mod, row, col}.
// Unlisted codes return an all-zero (invalid) entry.
module einstein_kbd_map
  import einstein_kbd_pkg::*;
(
  input  logic       ext,
  input  logic [7:0] code,
  output map_entry_t ent
);

  always_comb begin
    ent = '0;
    case ({ext, code})
      9'h016: ent = mk_key(3'd0, 3'd0);
      9'h01E: ent = mk_key(3'd0, 3'd1);
      9'h026: ent = mk_key(3'd0, 3'd2);
      9'h025: ent = mk_key(3'd0, 3'd3);
      9'h02E: ent = mk_key(3'd0, 3'd4);
      9'h036: ent = mk_key(3'd0, 3'd5);
      9'h05A, 9'h15A: ent = mk_key(3'd0, 3'd6);
      9'h066: ent = mk_key(3'd0, 3'd7);
      9'h015: ent = mk_key(3'd1, 3'd0);
      9'h01D: ent = mk_key(3'd1, 3'd1);
      9'h024: ent = mk_key(3'd1, 3'd2);
      9'h02D: ent = mk_key(3'd1, 3'd3);
      9'h02C: ent = mk_key(3'd1, 3'd4);
      9'h035: ent = mk_key(3'd1, 3'd5);
      9'h03C: ent = mk_key(3'd1, 3'd6);
      9'h043: ent = mk_key(3'd1, 3'd7);
      9'h00D: ent = mk_key(3'd2, 3'd0);
      9'h01C: ent = mk_key(3'd2, 3'd1);
      9'h01B: ent = mk_key(3'd2, 3'd2);
      9'h023: ent = mk_key(3'd2, 3'd3);
      9'h02B: ent = mk_key(3'd2, 3'd4);
      9'h034: ent = mk_key(3'd2, 3'd5);
      9'h033: ent = mk_key(3'd2, 3'd6);
      9'h03B: ent = mk_key(3'd2, 3'd7);
      9'h01A: ent = mk_key(3'd3, 3'd0);
      9'h022: ent = mk_key(3'd3, 3'd1);
      9'h021: ent = mk_key(3'd3, 3'd2);
      9'h02A: ent = mk_key(3'd3, 3'd3);
      9'h032: ent = mk_key(3'd3, 3'd4);
      9'h031: ent = mk_key(3'd3, 3'd5);
      9'h03A: ent = mk_key(3'd3, 3'd6);
      9'h029: ent = mk_key(3'd3, 3'd7);
      9'h175: ent = mk_key(3'd4, 3'd0);
      9'h172: ent = mk_key(3'd4, 3'd1);
      9'h16B: ent = mk_key(3'd4, 3'd2);
      9'h174: ent = mk_key(3'd4, 3'd3);
      9'h012: ent = mk_mod(MOD_SHIFT, 3'd0);
      9'h059: ent = mk_mod(MOD_SHIFT, 3'd1);
      9'h014, 9'h114: ent = mk_mod(MOD_CTRL, 3'd0);
      9'h011, 9'h111: ent = mk_mod(MOD_GRAPH, 3'd0);
      default: ent = '0;
    endcase
  end

endmodule

// File: rtl/einstein_kbd_matrix.sv
// PS/2 receiver + make/break decoder driving the Einstein 8x8 key matrix; kb_col follows
// kb_row one cycle later. Optional frame timeout via `define KBD_RX_TIMEOUT_EN.
module einstein_kbd_matrix
  import einstein_kbd_pkg::*;
#(
  parameter int FILTER_LEN = DEF_FILTER_LEN
`ifdef KBD_RX_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
`endif
) (
  input  logic                         clk_sys,
  input  logic                         reset,
  input  logic                         ps2_clk,
  input  logic                         ps2_data,
  einstein_kbd_matrix_if.master        kbd,
  output logic                         rx_err
);

  localparam int               FLT_W    = $clog2(FILTER_LEN + 1);
  localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(FILTER_LEN - 1);

  logic [1:0]       clk_sync, dat_sync;
  logic             filt_clk;
  logic [FLT_W-1:0] flt_cnt;
  logic             fall, rx_bit, parity_ok, rx_timeout;
  rx_state_t        state, state_nxt;
  logic [2:0]       bit_cnt;
  logic [7:0]       rx_shift;
  logic             shift_en, byte_vld, frame_err;
  map_entry_t       ent;

  logic [7:0][7:0]  key, key_nxt;
  logic             shift_l, shift_r, ctrl_on, graph_on, ext, brk;
  logic             shl_nxt, shr_nxt, ctrl_nxt, graph_nxt, ext_nxt, brk_nxt;
  logic [2:0]       skip, skip_nxt;
  logic [7:0]       col_q, col_nxt;

  // Idle PS/2 lines are high, so the conditioning chain resets to 1.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      filt_clk <= 1'b1;
      flt_cnt  <= '0;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_data};
      if (clk_sync[1] == filt_clk) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FLT_LAST) begin
        filt_clk <= clk_sync[1];
        flt_cnt  <= '0;
      end else begin
        flt_cnt <= flt_cnt + 1'b1;
      end
    end
  end

  assign fall      = filt_clk & ~clk_sync[1] & (flt_cnt == FLT_LAST);
  assign rx_bit    = dat_sync[1];
  assign parity_ok = ^{rx_bit, rx_shift};

`ifdef KBD_RX_TIMEOUT_EN
  localparam int              TO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] to_cnt;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset)                          to_cnt <= '0;
    else if (state == RX_IDLE || fall)  to_cnt <= '0;
    else                                to_cnt <= to_cnt + 1'b1;
  end
  assign rx_timeout = (state != RX_IDLE) && (to_cnt == TO_LAST);
`else
  assign rx_timeout = 1'b0;
`endif

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) state <= RX_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (fall) begin
      case (state)
        RX_IDLE:   if (!rx_bit) state_nxt = RX_DATA;
        RX_DATA:   if (bit_cnt == 3'd7) state_nxt = RX_PARITY;
        RX_PARITY: state_nxt = parity_ok ? RX_STOP : RX_IDLE;
        RX_STOP:   state_nxt = RX_IDLE;
      endcase
    end
    if (rx_timeout) state_nxt = RX_IDLE;
  end

  always_comb begin
    shift_en  = fall && (state == RX_DATA);
    byte_vld  = fall && (state == RX_STOP) && rx_bit;
    frame_err = (fall && (((state == RX_PARITY) && !parity_ok) ||
                          ((state == RX_STOP) && !rx_bit))) || rx_timeout;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      bit_cnt  <= '0;
      rx_shift <= '0;
      rx_err   <= 1'b0;
    end else begin
      rx_err <= frame_err;
      if (fall && state == RX_IDLE) bit_cnt <= '0;
      else if (shift_en)            bit_cnt <= bit_cnt + 3'd1;
      if (shift_en) rx_shift <= {rx_bit, rx_shift[7:1]};
    end
  end

  einstein_kbd_map u_map (
    .ext  (ext),
    .code (rx_shift),
    .ent  (ent)
  );

  always_comb begin
    key_nxt   = key;
    shl_nxt   = shift_l;
    shr_nxt   = shift_r;
    ctrl_nxt  = ctrl_on;
    graph_nxt = graph_on;
    ext_nxt   = ext;
    brk_nxt   = brk;
    skip_nxt  = skip;
    if (byte_vld) begin
      if (skip != 3'd0)                skip_nxt = skip - 3'd1;
      else if (rx_shift == PFX_PAUSE)  skip_nxt = PAUSE_SKIP;
      else if (rx_shift == PFX_EXT)    ext_nxt  = 1'b1;
      else if (rx_shift == PFX_BRK)    brk_nxt  = 1'b1;
      else begin
        ext_nxt = 1'b0;
        brk_nxt = 1'b0;
        if (ent.valid) begin
          case (ent.mod)
            MOD_NONE:  key_nxt[ent.row][ent.col] = ~brk;
            MOD_SHIFT: if (ent.col[0]) shr_nxt = ~brk; else shl_nxt = ~brk;
            MOD_CTRL:  ctrl_nxt  = ~brk;
            MOD_GRAPH: graph_nxt = ~brk;
          endcase
        end
      end
    end
    if (rx_timeout) begin
      ext_nxt  = 1'b0;
      brk_nxt  = 1'b0;
      skip_nxt = 3'd0;
    end
  end

  // Column scan uses the next-state matrix so a same-cycle key update and row change both show.
  always_comb begin
    col_nxt = 8'hFF;
    for (int c = 0; c < 8; c++)
      for (int r = 0; r < 8; r++)
        if (!kbd.kb_row[r] && key_nxt[r][c]) col_nxt[c] = 1'b0;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      key      <= '0;
      shift_l  <= 1'b0;
      shift_r  <= 1'b0;
      ctrl_on  <= 1'b0;
      graph_on <= 1'b0;
      ext      <= 1'b0;
      brk      <= 1'b0;
      skip     <= 3'd0;
      col_q    <= 8'hFF;
    end else begin
      key      <= key_nxt;
      shift_l  <= shl_nxt;
      shift_r  <= shr_nxt;
      ctrl_on  <= ctrl_nxt;
      graph_on <= graph_nxt;
      ext      <= ext_nxt;
      brk      <= brk_nxt;
      skip     <= skip_nxt;
      col_q    <= col_nxt;
    end
  end

  assign kbd.kb_col   = col_q;
  assign kbd.kb_shift = ~(shift_l | shift_r);
  assign kbd.kb_ctrl  = ~ctrl_on;
  assign kbd.kb_graph = ~graph_on;

endmodule

// File: tb/tb_einstein_kbd_matrix.sv
// Bench for einstein_kbd_matrix: PS/2 frames from directed and random scan-code streams,
// compared against a byte-level keyboard model.
module tb_einstein_kbd_matrix;

  localparam int HALF = 14;
`ifdef KBD_RX_TIMEOUT_EN
  localparam int TB_TIMEOUT = 4000;
`endif

  logic clk_sys = 1'b0;
  logic reset;
  logic ps2_clk, ps2_data;
  logic rx_err;

  einstein_kbd_matrix_if kbd ();

  einstein_kbd_matrix #(
    .FILTER_LEN (8)
`ifdef KBD_RX_TIMEOUT_EN
    , .TIMEOUT_CYCLES (TB_TIMEOUT)
`endif
  ) dut (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .kbd      (kbd.master),
    .rx_err   (rx_err)
  );

  always #5 clk_sys = ~clk_sys;

  int n_tests = 0;
  int n_fail  = 0;
  int err_pulses = 0;
  int exp_err = 0;

  always @(posedge clk_sys) if (rx_err === 1'b1) err_pulses++;

  // Keyboard model: a 64-key array, four modifier flags and the prefix state.
  bit m_key [8][8];
  bit m_shl, m_shr, m_ctrl, m_graph, m_ext, m_brk;
  int m_skip;

  localparam int NK = 9;
  logic [8:0] k_code [NK] = '{9'h01C, 9'h05A, 9'h15A, 9'h015, 9'h01A, 9'h029, 9'h016, 9'h175, 9'h03B};
  int         k_row  [NK] = '{2, 0, 0, 1, 3, 3, 0, 4, 2};
  int         k_col  [NK] = '{1, 6, 6, 0, 0, 7, 0, 0, 7};
  logic [8:0] mod_code [6] = '{9'h012, 9'h059, 9'h014, 9'h114, 9'h011, 9'h111};
  logic [8:0] unm_code [4] = '{9'h076, 9'h005, 9'h07E, 9'h112};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    foreach (m_key[r, c]) m_key[r][c] = 1'b0;
    {m_shl, m_shr, m_ctrl, m_graph, m_ext, m_brk} = '0;
    m_skip = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    bit mk;
    mk = !m_brk;
    if (m_skip > 0) m_skip--;
    else if (b == 8'hE1) m_skip = 7;
    else if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else begin
      if (!m_ext && b == 8'h12)      m_shl = mk;
      else if (!m_ext && b == 8'h59) m_shr = mk;
      else if (b == 8'h14)           m_ctrl = mk;
      else if (b == 8'h11)           m_graph = mk;
      else
        for (int i = 0; i < NK; i++)
          if (k_code[i] == {m_ext, b}) m_key[k_row[i]][k_col[i]] = mk;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  function automatic logic [7:0] exp_col(input logic [7:0] row);
    logic [7:0] v;
    v = 8'hFF;
    for (int c = 0; c < 8; c++)
      for (int r = 0; r < 8; r++)
        if (!row[r] && m_key[r][c]) v[c] = 1'b0;
    return v;
  endfunction

  task automatic ps2_bit(input logic v);
    ps2_data = v;
    repeat (HALF) @(posedge clk_sys);
    #1 ps2_clk = 1'b0;
    repeat (HALF) @(posedge clk_sys);
    #1 ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit((~^b) ^ bad_par);
    ps2_bit(1'b1);
    repeat (HALF) @(posedge clk_sys);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b0);
    model_byte(b);
  endtask

  task automatic send_code(input logic [8:0] code, input bit brk);
    if (code[8]) send(8'hE0);
    if (brk)     send(8'hF0);
    send(code[7:0]);
  endtask

  task automatic scan(input string tag, input logic [7:0] row);
    @(posedge clk_sys);
    #1 kbd.kb_row = row;
    @(posedge clk_sys);
    #1 chk(tag, {24'd0, kbd.kb_col}, {24'd0, exp_col(row)});
  endtask

  task automatic check_state(input string tag);
    scan({tag, "_col_rand"}, 8'($urandom_range(0, 255)));
    scan({tag, "_col_all"}, 8'h00);
    chk({tag, "_shift"}, {31'd0, kbd.kb_shift}, {31'd0, ~(m_shl | m_shr)});
    chk({tag, "_ctrl"},  {31'd0, kbd.kb_ctrl},  {31'd0, ~m_ctrl});
    chk({tag, "_graph"}, {31'd0, kbd.kb_graph}, {31'd0, ~m_graph});
    chk({tag, "_errcnt"}, err_pulses, exp_err);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int w;
    int start;
    model_reset();
    reset = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; kbd.kb_row = 8'h00;
    repeat (3) @(posedge clk_sys);
    #1;
    chk("rst_col",   {24'd0, kbd.kb_col}, 32'hFF);
    chk("rst_shift", {31'd0, kbd.kb_shift}, 32'd1);
    chk("rst_ctrl",  {31'd0, kbd.kb_ctrl},  32'd1);
    chk("rst_graph", {31'd0, kbd.kb_graph}, 32'd1);
    chk("rst_rxerr", {31'd0, rx_err}, 32'd0);
    reset = 1'b0;
    kbd.kb_row = 8'hFF;
    repeat (4) @(posedge clk_sys);

    // Make/break 'A'.
    send(8'h1C);
    scan("a_make_FB", 8'hFB);
    chk("a_make_exact", {24'd0, kbd.kb_col}, 32'hFD);
    scan("a_row_FF", 8'hFF);
    chk("a_rowff_exact", {24'd0, kbd.kb_col}, 32'hFF);
    send(8'hF0); send(8'h1C);
    scan("a_brk_FB", 8'hFB);

    // Both shifts overlap; CTRL via extended codes.
    send(8'h12); send(8'h59); send(8'hF0); send(8'h12);
    chk("shift_held", {31'd0, kbd.kb_shift}, 32'd0);
    send(8'hF0); send(8'h59);
    chk("shift_rel", {31'd0, kbd.kb_shift}, 32'd1);
    send(8'hE0); send(8'h14);
    chk("ctrl_make", {31'd0, kbd.kb_ctrl}, 32'd0);
    send(8'hE0); send(8'hF0); send(8'h14);
    chk("ctrl_brk", {31'd0, kbd.kb_ctrl}, 32'd1);

    // Two rows strobed together.
    send(8'h1C); send(8'h5A);
    scan("multirow_FA", 8'hFA);
    chk("multirow_exact", {24'd0, kbd.kb_col}, 32'hBD);
    send(8'hF0); send(8'h1C); send(8'hF0); send(8'h5A);

    // Bad parity is dropped, next good frame is taken.
    send_frame(8'h1C, 1'b1);
    exp_err++;
    chk("badpar_err", err_pulses, exp_err);
    scan("badpar_col", 8'hFB);
    send(8'h1C);
    scan("after_bad_col", 8'hFB);
    send(8'hF0); send(8'h1C);

    // Pause sequence is swallowed.
    foreach (k_code[i]) begin end
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    send(8'h1C);
    scan("pause_col", 8'h00);
    chk("pause_exact", {24'd0, kbd.kb_col}, 32'hFD);
    chk("pause_ctrl", {31'd0, kbd.kb_ctrl}, 32'd1);
    check_state("pause");

    // Random make/break/modifier/unmapped traffic.
    for (int it = 0; it < 20; it++) begin
      case ($urandom_range(0, 5))
        0, 1: send_code(k_code[$urandom_range(0, NK - 1)], 1'b0);
        2:    send_code(k_code[$urandom_range(0, NK - 1)], 1'b1);
        3:    send_code(mod_code[$urandom_range(0, 5)], bit'($urandom_range(0, 1)));
        4:    send_code(unm_code[$urandom_range(0, 3)], bit'($urandom_range(0, 1)));
        default: begin
          k = $urandom_range(0, NK - 1);
          send_code(k_code[k], 1'b0);
          send_code(k_code[k], 1'b0);
        end
      endcase
      check_state($sformatf("rnd%0d", it));
    end

    // Reset in the middle of a prefix and a frame.
    send(8'h1C); send(8'h12); send(8'hE0); send(8'h14); send(8'hE0);
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    kbd.kb_row = 8'h00;
    #1 reset = 1'b1;
    repeat (2) @(posedge clk_sys);
    #1;
    chk("midrst_col",   {24'd0, kbd.kb_col}, 32'hFF);
    chk("midrst_shift", {31'd0, kbd.kb_shift}, 32'd1);
    chk("midrst_ctrl",  {31'd0, kbd.kb_ctrl},  32'd1);
    chk("midrst_rxerr", {31'd0, rx_err}, 32'd0);
    reset = 1'b0;
    ps2_data = 1'b1;
    model_reset();
    repeat (4) @(posedge clk_sys);
    send(8'h1C);
    scan("postrst_col", 8'hFB);
    chk("postrst_exact", {24'd0, kbd.kb_col}, 32'hFD);

`ifdef KBD_RX_TIMEOUT_EN
    // Stalled frame after a break prefix: timeout must also drop the prefix.
    send(8'hF0); send(8'h1C);
    send(8'hF0);
    ps2_bit(1'b0);
    for (int i = 0; i < 3; i++) ps2_bit(1'b0);
    ps2_data = 1'b1;
    start = err_pulses;
    w = 0;
    while (err_pulses == start && w < TB_TIMEOUT + 500) begin
      @(posedge clk_sys);
      w++;
    end
    #1;
    exp_err++;
    m_ext = 1'b0; m_brk = 1'b0; m_skip = 0;
    chk("timeout_err", err_pulses, exp_err);
    send(8'h1C);
    scan("timeout_next", 8'hFB);
    chk("timeout_exact", {24'd0, kbd.kb_col}, 32'hFD);
`endif

    w = 0;
    start = 0;
    check_state("final");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/einstein_kbd_matrix.md
Name: einstein_kbd_matrix

Overview:
- Keyboard end of the Einstein keyboard interface.
- Receives raw PS/2 frames and decodes make/break/extended codes into a 64-key matrix plus SHIFT/CTRL/GRAPH modifiers.
- Answers the PSG port-A row strobe with port-B column data, using the same active-low polarity as the real keyboard.
- Sits between the PS/2 pins and the `kb_row`/`kb_col`/`kb_shift`/`kb_ctrl`/`kb_graph` nets of the machine top.

Parameters:
- `FILTER_LEN`, 8: consecutive equal `clk_sys` samples required before the filtered `ps2_clk` changes.
- `TIMEOUT_CYCLES`, 64000: `clk_sys` cycles without a falling `ps2_clk` edge before a partial frame is aborted (2 ms at 32 MHz).

Ports:
- `clk_sys` in 1: system clock, 32 MHz.
- `reset` in 1: asynchronous, active-high.
- `ps2_clk` in 1: raw PS/2 clock, asynchronous.
- `ps2_data` in 1: raw PS/2 data, asynchronous.
- `kb_row` in 8: row select from PSG IOA_out, active low, several rows may be low at once.
- `kb_col` out 8: column return to PSG IOB_in, active low.
- `kb_shift` out 1: SHIFT held, active low.
- `kb_ctrl` out 1: CTRL held, active low.
- `kb_graph` out 1: GRAPH held, active low.
- `rx_err` out 1: one-cycle pulse on a framing, parity or timeout error.

Behaviour:
- Reset, clock and pin conditioning:
  - Reset is `reset`, asynchronous, active-high; the clock is `clk_sys`.
  - Reset values: `kb_col`=8'hFF, `kb_shift`=`kb_ctrl`=`kb_graph`=1, `rx_err`=0, matrix all released, all FSMs idle, all flags clear.
  - `ps2_clk` and `ps2_data` each pass through a 2-FF synchroniser.
  - `ps2_clk` is then debounced by `FILTER_LEN`. A data bit is sampled on the filtered falling edge.
- Receiver FSM, states IDLE, DATA, PARITY, STOP:
  - IDLE: on a falling edge with data=0, go to DATA with the bit count at 0. Data=1 on a falling edge is ignored (stay in IDLE).
  - DATA: shift in LSB first; after the 8th bit go to PARITY.
  - PARITY: data must make the 9 bits odd.
  - STOP: data must be 1. On success, assert an internal `byte_valid` for 1 cycle with the byte, then return to IDLE.
  - Parity or stop failure: pulse `rx_err`, drop the byte, go to IDLE.
- Decoder, acting on `byte_valid`:
  - 0xE0 sets `ext`; 0xF0 sets `brk`. Both persist until the next other byte.
  - 0xE1 loads a skip counter with 7; the next 7 bytes are discarded (Pause sequence) and leave the flags untouched.
  - Any other byte plus `ext` indexes the map. The result is {valid, mod[1:0], row[2:0], col[2:0]}.
  - A matrix hit sets key[row][col] = ~brk.
  - Modifier codes:
    - 0x12 and 0x59 drive separate shift_l/shift_r bits; `kb_shift` = ~(shift_l|shift_r).
    - 0x14 and E0 14 drive `kb_ctrl`.
    - 0x11 and E0 11 drive `kb_graph`.
  - Unmapped code: no effect.
  - `ext` and `brk` clear after every non-prefix byte, mapped or not.
  - Releasing a key that is not pressed, or repeating a make (typematic), is idempotent.
- Column output:
  - `kb_col`[c] registered: 0 if any row r with `kb_row`[r]=0 has key[r][c]=1, else 1.
  - `kb_row` change to `kb_col` valid: 1 cycle latency.
  - `kb_row`=8'hFF gives `kb_col`=8'hFF.
  - A matrix update and a row change in the same cycle: the next cycle reflects both.
- Asserting `reset` mid-frame or mid-prefix discards everything and releases all keys.

Optional Feature:
- Macro `KBD_RX_TIMEOUT_EN`.
- With it: a counter reloads on every filtered falling edge while the receiver is not IDLE. Reaching `TIMEOUT_CYCLES` forces IDLE, pulses `rx_err`, and clears `ext`, `brk` and the skip counter.
- Without it: the counter and `TIMEOUT_CYCLES` usage are compiled out. A truncated frame stays pending until enough edges arrive.

Decomposition:
- Package `einstein_kbd_pkg`:
  - receiver state enum;
  - prefix constants 0xE0/0xF0/0xE1;
  - modifier encodings (NONE/SHIFT/CTRL/GRAPH);
  - map-entry struct {valid, mod, row, col};
  - default `FILTER_LEN`/`TIMEOUT_CYCLES`.
- The package map fixes 0x1C ('A') at row 2 col 1 and 0x5A (RETURN) at row 0 col 6.
- Sub-module `einstein_kbd_map`: purely combinational {ext, code[7:0]} → map entry. The matrix and FSM stay in the top module.

Test Plan:
- Make 'A':
  - send frame 0x1C, `kb_row`=8'hFB → `kb_col`=8'hFD one cycle later;
  - `kb_row`=8'hFF → 8'hFF;
  - send F0 1C → `kb_col`=8'hFF.
- Modifiers:
  - send 12, then 59, then F0 12 → `kb_shift` stays 0;
  - then F0 59 → `kb_shift`=1;
  - E0 14 → `kb_ctrl`=0;
  - E0 F0 14 → `kb_ctrl`=1.
- Multi-row scan: press 0x1C and 0x5A, `kb_row`=8'hFA → `kb_col`=8'hBD.
- Bad frames:
  - frame 0x1C with even parity → `rx_err` pulse, matrix unchanged;
  - the following good 0x1C is accepted.
- Pause sequence: send E1 14 77 E1 F0 14 F0 77 then 0x1C → only (row 2, col 1) set; no `kb_ctrl` change.
- Reset and timeout:
  - assert `reset` after 4 data bits with keys held → all outputs return to reset values;
  - with `KBD_RX_TIMEOUT_EN`, stop clocking mid-frame for 64000 cycles → `rx_err` pulse, the next full frame decodes correctly.
